// File: rtl/layer_sched.sv
// layer_sched: frame-synchronous scheduler and compositor for the three-layer
// VGA path. Turns vertical-sync edges into a one-cycle frame strobe, drives the
// fade-out / swap / fade-in mode sequencer and the animation step pulses, and
// composites the up/mid/down layers through a 2-stage saturate-and-scale pipe.
module layer_sched #(
  parameter int UP_DIV    = 4,
  parameter int DOWN_DIV  = 8,
  parameter int FADE_STEP = 16
) (
  input  logic       VGA_CLK,
  input  logic       reset,
  input  logic       vga_v_sync,
  input  logic       vga_h_sync,
  input  logic       inDisplayArea,
  input  logic [2:0] sel,
  input  logic [7:0] play,
  input  logic [7:0] r_up,
  input  logic [7:0] g_up,
  input  logic [7:0] b_up,
  input  logic [7:0] r_mid,
  input  logic [7:0] g_mid,
  input  logic [7:0] b_mid,
  input  logic [7:0] r_down,
  input  logic [7:0] g_down,
  input  logic [7:0] b_down,
  output logic [2:0] sel_active,
  output logic       up_step,
  output logic       down_step,
  output logic [7:0] brightness,
  output logic [7:0] vga_R,
  output logic [7:0] vga_G,
  output logic [7:0] vga_B,
  output logic       hs_o,
  output logic       vs_o,
  output logic       de_o
);

  localparam int UP_W   = (UP_DIV > 1) ? $clog2(UP_DIV) : 1;
  localparam int DOWN_W = (DOWN_DIV > 1) ? $clog2(DOWN_DIV) : 1;
  localparam logic [8:0] FADE_STEP_9 = 9'(FADE_STEP);
  localparam logic [UP_W-1:0]   UP_LAST   = UP_W'(UP_DIV - 1);
  localparam logic [DOWN_W-1:0] DOWN_LAST = DOWN_W'(DOWN_DIV - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FADE_OUT = 2'd1,
    ST_SWAP     = 2'd2,
    ST_FADE_IN  = 2'd3
  } state_t;

  // Three-input channel sum, clamped to full scale instead of wrapping.
  function automatic logic [7:0] sat_sum(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c);
    logic [9:0] s;
    s = {2'b00, a} + {2'b00, b} + {2'b00, c};
    if (s > 10'd255) begin
      return 8'd255;
    end else begin
      return s[7:0];
    end
  endfunction

  // Scale by (brightness + 1) / 256 so that 255 is identity and 0 is black.
  function automatic logic [7:0] scale(input logic [7:0] s, input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, s} * ({8'd0, b} + 16'd1);
    return 8'(p >> 8);
  endfunction

  logic                vs_q_r;
  logic                fs_r;
  state_t              state_r;
  logic [7:0]          bright_r;
  logic [2:0]          sel_active_r;
  logic [UP_W-1:0]     up_cnt_r;
  logic [DOWN_W-1:0]   down_cnt_r;
  logic                up_step_r;
  logic                down_step_r;
  logic [7:0]          bright_inc_s;
  logic [7:0]          bright_dec_s;
  logic [8:0]          bright_sum_s;

  logic [7:0]          r_s1_r, g_s1_r, b_s1_r, bright_s1_r;
  logic                hs_s1_r, vs_s1_r, de_s1_r;
  logic [7:0]          r_s2_r, g_s2_r, b_s2_r;
  logic                hs_s2_r, vs_s2_r, de_s2_r;

  // Register vsync and raise a one-cycle frame strobe on its falling edge.
  always_ff @(posedge VGA_CLK or negedge reset) begin
    if (!reset) begin
      vs_q_r <= 1'b1;
      fs_r   <= 1'b0;
    end else begin
      vs_q_r <= vga_v_sync;
      fs_r   <= vs_q_r & ~vga_v_sync;
    end
  end

  // Clamped brightness up/down candidates, computed in 9 bits.
  always_comb begin
    bright_sum_s = {1'b0, bright_r} + FADE_STEP_9;
    if (bright_sum_s > 9'd255) begin
      bright_inc_s = 8'd255;
    end else begin
      bright_inc_s = bright_sum_s[7:0];
    end
    if ({1'b0, bright_r} <= FADE_STEP_9) begin
      bright_dec_s = 8'd0;
    end else begin
      bright_dec_s = 8'({1'b0, bright_r} - FADE_STEP_9);
    end
  end

  // Mode sequencer: advances once per frame strobe; a reversal of the request
  // mid-fade turns the fade around without changing brightness that frame.
  always_ff @(posedge VGA_CLK or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_FADE_IN;
      bright_r     <= 8'd0;
      sel_active_r <= 3'd0;
    end else if (fs_r) begin
      case (state_r)
        ST_RUN: begin
          bright_r <= 8'd255;
          if (sel != sel_active_r) begin
            state_r <= ST_FADE_OUT;
          end
        end
        ST_FADE_OUT: begin
          if (sel == sel_active_r) begin
            state_r <= ST_FADE_IN;
          end else begin
            bright_r <= bright_dec_s;
            if (bright_dec_s == 8'd0) begin
              state_r <= ST_SWAP;
            end
          end
        end
        ST_SWAP: begin
          bright_r     <= 8'd0;
          sel_active_r <= sel;
          state_r      <= ST_FADE_IN;
        end
        ST_FADE_IN: begin
          if (sel != sel_active_r) begin
            state_r <= ST_FADE_OUT;
          end else begin
            bright_r <= bright_inc_s;
            if (bright_inc_s == 8'd255) begin
              state_r <= ST_RUN;
            end
          end
        end
        default: begin
          state_r  <= ST_FADE_IN;
          bright_r <= 8'd0;
        end
      endcase
    end
  end

  // Frame-divided animation steps; counters restart on the swap frame so a new
  // mode begins its animation in phase.
  always_ff @(posedge VGA_CLK or negedge reset) begin
    if (!reset) begin
      up_cnt_r    <= '0;
      down_cnt_r  <= '0;
      up_step_r   <= 1'b0;
      down_step_r <= 1'b0;
    end else begin
      up_step_r   <= 1'b0;
      down_step_r <= 1'b0;
      if (fs_r) begin
        if (state_r == ST_SWAP) begin
          up_cnt_r   <= '0;
          down_cnt_r <= '0;
        end else if (play != 8'd0) begin
          if (up_cnt_r == UP_LAST) begin
            up_cnt_r  <= '0;
            up_step_r <= 1'b1;
          end else begin
            up_cnt_r <= up_cnt_r + UP_W'(1);
          end
          if (down_cnt_r == DOWN_LAST) begin
            down_cnt_r  <= '0;
            down_step_r <= 1'b1;
          end else begin
            down_cnt_r <= down_cnt_r + DOWN_W'(1);
          end
        end
      end
    end
  end

  // Pipe stage 1: saturating layer sum, blanked outside the visible area;
  // brightness is captured with the pixel so it never changes mid-pixel.
  always_ff @(posedge VGA_CLK or negedge reset) begin
    if (!reset) begin
      r_s1_r      <= 8'd0;
      g_s1_r      <= 8'd0;
      b_s1_r      <= 8'd0;
      bright_s1_r <= 8'd0;
      hs_s1_r     <= 1'b1;
      vs_s1_r     <= 1'b1;
      de_s1_r     <= 1'b0;
    end else begin
      if (inDisplayArea) begin
        r_s1_r <= sat_sum(r_up, r_mid, r_down);
        g_s1_r <= sat_sum(g_up, g_mid, g_down);
        b_s1_r <= sat_sum(b_up, b_mid, b_down);
      end else begin
        r_s1_r <= 8'd0;
        g_s1_r <= 8'd0;
        b_s1_r <= 8'd0;
      end
      bright_s1_r <= bright_r;
      hs_s1_r     <= vga_h_sync;
      vs_s1_r     <= vga_v_sync;
      de_s1_r     <= inDisplayArea;
    end
  end

  // Pipe stage 2: brightness scaling and matching sync/enable delay.
  always_ff @(posedge VGA_CLK or negedge reset) begin
    if (!reset) begin
      r_s2_r  <= 8'd0;
      g_s2_r  <= 8'd0;
      b_s2_r  <= 8'd0;
      hs_s2_r <= 1'b1;
      vs_s2_r <= 1'b1;
      de_s2_r <= 1'b0;
    end else begin
      r_s2_r  <= scale(r_s1_r, bright_s1_r);
      g_s2_r  <= scale(g_s1_r, bright_s1_r);
      b_s2_r  <= scale(b_s1_r, bright_s1_r);
      hs_s2_r <= hs_s1_r;
      vs_s2_r <= vs_s1_r;
      de_s2_r <= de_s1_r;
    end
  end

  assign sel_active = sel_active_r;
  assign up_step    = up_step_r;
  assign down_step  = down_step_r;
  assign brightness = bright_r;
  assign vga_R      = r_s2_r;
  assign vga_G      = g_s2_r;
  assign vga_B      = b_s2_r;
  assign hs_o       = hs_s2_r;
  assign vs_o       = vs_s2_r;
  assign de_o       = de_s2_r;

endmodule

// File: tb/tb_layer_sched.sv
// Directed bench for layer_sched: fade sequencing, step pulses, compositor.
module tb_layer_sched;

  logic       VGA_CLK = 1'b0;
  logic       reset, vga_v_sync, vga_h_sync, inDisplayArea;
  logic [2:0] sel;
  logic [7:0] play;
  logic [7:0] r_up, g_up, b_up, r_mid, g_mid, b_mid, r_down, g_down, b_down;
  logic [2:0] sel_active;
  logic       up_step, down_step;
  logic [7:0] brightness, vga_R, vga_G, vga_B;
  logic       hs_o, vs_o, de_o;

  int n_vec = 0;
  int n_err = 0;
  int up_cnt = 0, down_cnt = 0, both_cnt = 0, wide_cnt = 0;
  logic up_prev = 1'b0, down_prev = 1'b0;

  layer_sched dut (
    .VGA_CLK(VGA_CLK), .reset(reset), .vga_v_sync(vga_v_sync), .vga_h_sync(vga_h_sync),
    .inDisplayArea(inDisplayArea), .sel(sel), .play(play),
    .r_up(r_up), .g_up(g_up), .b_up(b_up), .r_mid(r_mid), .g_mid(g_mid), .b_mid(b_mid),
    .r_down(r_down), .g_down(g_down), .b_down(b_down),
    .sel_active(sel_active), .up_step(up_step), .down_step(down_step),
    .brightness(brightness), .vga_R(vga_R), .vga_G(vga_G), .vga_B(vga_B),
    .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  // Count step pulses and flag any pulse wider than one cycle.
  always @(negedge VGA_CLK) begin
    if (up_step === 1'b1) up_cnt++;
    if (down_step === 1'b1) down_cnt++;
    if (up_step === 1'b1 && down_step === 1'b1) both_cnt++;
    if ((up_step === 1'b1 && up_prev) || (down_step === 1'b1 && down_prev)) wide_cnt++;
    up_prev   = (up_step === 1'b1);
    down_prev = (down_step === 1'b1);
  end

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_pulses();
    up_cnt = 0; down_cnt = 0; both_cnt = 0;
  endtask

  // One frame of 10 cycles: vsync low for 2, high for 8; starts and ends on negedge.
  task automatic frame();
    vga_v_sync = 1'b0;
    repeat (2) @(negedge VGA_CLK);
    vga_v_sync = 1'b1;
    repeat (8) @(negedge VGA_CLK);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_val({tag, "_bright"}, 32'(brightness), 32'd0);
    chk_val({tag, "_sel_active"}, 32'(sel_active), 32'd0);
    chk_val({tag, "_up_step"}, 32'(up_step), 32'd0);
    chk_val({tag, "_down_step"}, 32'(down_step), 32'd0);
    chk_val({tag, "_vga_R"}, 32'(vga_R), 32'd0);
    chk_val({tag, "_vga_G"}, 32'(vga_G), 32'd0);
    chk_val({tag, "_hs_o"}, 32'(hs_o), 32'd1);
    chk_val({tag, "_vs_o"}, 32'(vs_o), 32'd1);
    chk_val({tag, "_de_o"}, 32'(de_o), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; vga_v_sync = 1'b1; vga_h_sync = 1'b1; inDisplayArea = 1'b0;
    sel = 3'd0; play = 8'd1;
    r_up = 8'd0; g_up = 8'd0; b_up = 8'd0; r_mid = 8'd0; g_mid = 8'd0; b_mid = 8'd0;
    r_down = 8'd0; g_down = 8'd0; b_down = 8'd0;
    repeat (2) @(negedge VGA_CLK);
    chk_reset_vals("por");
    reset = 1'b1;
    @(negedge VGA_CLK);

    // Power-up fade-in: min(255, 16k) after frame k.
    for (int k = 1; k <= 16; k++) begin
      frame();
      chk_val($sformatf("fadein_%0d", k), 32'(brightness), (k * 16 > 255) ? 32'd255 : 32'(k * 16));
    end
    chk_val("fadein_sel_active", 32'(sel_active), 32'd0);
    repeat (4) frame();
    chk_val("run_bright", 32'(brightness), 32'd255);

    // Step pulses: 16 playing frames, then 8 paused frames.
    clr_pulses();
    repeat (16) frame();
    chk_val("up_16f", 32'(up_cnt), 32'd4);
    chk_val("down_16f", 32'(down_cnt), 32'd2);
    clr_pulses();
    play = 8'd0;
    repeat (8) frame();
    chk_val("up_paused", 32'(up_cnt), 32'd0);
    chk_val("down_paused", 32'(down_cnt), 32'd0);
    // 36 counted frames so far: up phase 0, down phase 4 -> both pulse on 4th frame.
    play = 8'd1;
    repeat (3) frame();
    chk_val("up_hold_3", 32'(up_cnt), 32'd0);
    chk_val("down_hold_3", 32'(down_cnt), 32'd0);
    frame();
    chk_val("up_hold_4", 32'(up_cnt), 32'd1);
    chk_val("down_hold_4", 32'(down_cnt), 32'd1);
    chk_val("both_coincide", 32'(both_cnt), 32'd1);

    // Compositor at full brightness: 2-cycle latency, saturation, blanking.
    r_up = 8'd200; r_mid = 8'd100; r_down = 8'd0;
    g_up = 8'd10;  g_mid = 8'd20;  g_down = 8'd30;
    b_up = 8'd255; b_mid = 8'd255; b_down = 8'd255;
    inDisplayArea = 1'b1; vga_h_sync = 1'b0;
    @(negedge VGA_CLK);
    chk_val("pix_lat1_R", 32'(vga_R), 32'd0);
    chk_val("pix_lat1_de", 32'(de_o), 32'd0);
    @(negedge VGA_CLK);
    chk_val("pix_R_sat", 32'(vga_R), 32'd255);
    chk_val("pix_G", 32'(vga_G), 32'd60);
    chk_val("pix_B_sat", 32'(vga_B), 32'd255);
    chk_val("pix_de", 32'(de_o), 32'd1);
    chk_val("pix_hs", 32'(hs_o), 32'd0);
    inDisplayArea = 1'b0; vga_h_sync = 1'b1;
    repeat (2) @(negedge VGA_CLK);
    chk_val("pix_blank_R", 32'(vga_R), 32'd0);
    chk_val("pix_blank_de", 32'(de_o), 32'd0);
    inDisplayArea = 1'b1;

    // Mode change 0 -> 5; pause two fade frames so the swap frame would pulse.
    sel = 3'd5;
    frame();
    chk_val("fo_entry", 32'(brightness), 32'd255);
    play = 8'd0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 3) play = 8'd1;
      frame();
      chk_val($sformatf("fadeout_%0d", k), 32'(brightness), (16 * k > 255) ? 32'd0 : 32'(255 - 16 * k));
      if (k == 8) begin
        chk_val("pix_b127_R", 32'(vga_R), 32'd127);
        chk_val("pix_b127_G", 32'(vga_G), 32'd30);
      end
    end
    chk_val("pre_swap_sel_active", 32'(sel_active), 32'd0);
    clr_pulses();
    frame();
    chk_val("swap_sel_active", 32'(sel_active), 32'd5);
    chk_val("swap_bright", 32'(brightness), 32'd0);
    chk_val("swap_up", 32'(up_cnt), 32'd0);
    chk_val("swap_down", 32'(down_cnt), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      frame();
      chk_val($sformatf("fadein2_%0d", k), 32'(brightness), 32'(16 * k));
      if (k == 3) chk_val("cleared_up_3", 32'(up_cnt), 32'd0);
      if (k == 4) chk_val("cleared_up_4", 32'(up_cnt), 32'd1);
    end
    chk_val("cleared_down_6", 32'(down_cnt), 32'd0);
    chk_val("pix_b96_R", 32'(vga_R), 32'd96);
    vga_h_sync = 1'b0;
    repeat (2) @(negedge VGA_CLK);
    chk_val("pre_reset_hs", 32'(hs_o), 32'd0);

    // Asynchronous reset mid-fade.
    reset = 1'b0;
    #1;
    chk_reset_vals("midfade_rst");
    sel = 3'd0; vga_h_sync = 1'b1;
    @(negedge VGA_CLK);
    reset = 1'b1;
    @(negedge VGA_CLK);
    for (int k = 1; k <= 8; k++) begin
      frame();
      chk_val($sformatf("refade_%0d", k), 32'(brightness), 32'(16 * k));
    end

    // Fade reversal at 128.
    sel = 3'd3;
    frame();
    chk_val("rev_fo_128", 32'(brightness), 32'd128);
    sel = 3'd0;
    frame();
    chk_val("rev_fi_128", 32'(brightness), 32'd128);
    chk_val("pix_b128_R", 32'(vga_R), 32'd128);
    frame();
    chk_val("rev_fi_144", 32'(brightness), 32'd144);
    chk_val("rev_sel_active", 32'(sel_active), 32'd0);
    chk_val("pulse_width", 32'(wide_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
